alarm_zone_controller: RTL and testbench

//  Parametrised N-zone arming/alarm core for the home-alarm main board.
//  - Replaces the fixed two-sensor/one-siren logic: per-zone enable mask, timed exit and entry delays, siren timeout.
//  - Sits between the keypad decoder (ARM/DISARM pulses), the raw sensor pins and the siren driver / status serializer.

---
 rtl/alarm_zone_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_alarm_zone_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_zone_controller.sv
// -----------------------------------------------------------------------------
// alarm_zone_controller
//
// Purpose:
//    Parametrised N-zone arming/alarm core for the home-alarm main board.
//    It takes ARM/DISARM pulses from the keypad decoder and raw sensor levels.
//    It drives the siren and reports state to the status serializer.
//    It provides a per-zone enable mask, timed exit and entry delays, and a
//    siren timeout.
//
// Optional feature:
//    ALARM_TAMPER_EN - when defined, an open tamper loop forces ALARM from any
//    state. When undefined, TAMPER_IN is ignored and no tamper logic exists.
//
// Ports:
//    CLK_IN          in   system clock
//    RESET_IN        in   synchronous active-high reset
//    TICK_IN         in   1-cycle timebase strobe for all delays
//    SENSOR_IN       in   [N_ZONES] raw sensor levels, async, 1 = tripped
//    ZONE_EN_IN      in   [N_ZONES] zone enable mask
//    ARM_IN          in   1-cycle arm request
//    DISARM_IN       in   1-cycle valid-code disarm
//    TAMPER_IN       in   tamper loop, async, 1 = open
//    SIREN_OUT       out  siren drive
//    STATE_OUT       out  [3] current state encoding
//    ALARM_ZONES_OUT out  [N_ZONES] latched zones that caused/joined the alarm
//    ARM_FAIL_OUT    out  1-cycle pulse when an arm request is refused
//    STATUS_SEND_OUT out  1-cycle pulse after every state change
// -----------------------------------------------------------------------------
module alarm_zone_controller #(
   parameter int N_ZONES     = 4,
   parameter int CNT_W       = 8,
   parameter int EXIT_TICKS  = 30,
   parameter int ENTRY_TICKS = 15,
   parameter int SIREN_TICKS = 180
) (
   input  logic               CLK_IN,
   input  logic               RESET_IN,
   input  logic               TICK_IN,
   input  logic [N_ZONES-1:0] SENSOR_IN,
   input  logic [N_ZONES-1:0] ZONE_EN_IN,
   input  logic               ARM_IN,
   input  logic               DISARM_IN,
   input  logic               TAMPER_IN,
   output logic               SIREN_OUT,
   output logic [2:0]         STATE_OUT,
   output logic [N_ZONES-1:0] ALARM_ZONES_OUT,
   output logic               ARM_FAIL_OUT,
   output logic               STATUS_SEND_OUT
);

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4,
      S_SILENCED = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_TICKS);
   localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS);
   localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TICKS);

   state_t             r_state;
   state_t             w_nextState;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cntNext;
   logic [N_ZONES-1:0] r_sensSync1;
   logic [N_ZONES-1:0] r_sensSync2;
   logic [N_ZONES-1:0] w_trip;
   logic [N_ZONES-1:0] r_alarmZones;
   logic [N_ZONES-1:0] w_zonesNext;
   logic               w_anyTrip;
   logic               w_newTrip;
   logic               w_armFail;
   logic               w_stateChange;
   logic               w_tamper;
   logic               r_siren;
   logic               r_armFail;
   logic               r_statusSend;

   // Each timed state starts its delay from the full tick count; untimed
   // states park the counter at zero.
   function automatic logic [CNT_W-1:0] loadFor(input state_t s);
      case (s)
         S_EXIT:  loadFor = EXIT_LOAD;
         S_ENTRY: loadFor = ENTRY_LOAD;
         S_ALARM: loadFor = SIREN_LOAD;
         default: loadFor = '0;
      endcase
   endfunction

   // Two-flop synchronizer for the asynchronous sensor pins.
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         r_sensSync1 <= '0;
         r_sensSync2 <= '0;
      end else begin
         r_sensSync1 <= SENSOR_IN;
         r_sensSync2 <= r_sensSync1;
      end
   end

`ifdef ALARM_TAMPER_EN
   logic r_tampSync1;
   logic r_tampSync2;

   // The tamper loop gets the same two-flop synchronizer as the sensors.
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         r_tampSync1 <= 1'b0;
         r_tampSync2 <= 1'b0;
      end else begin
         r_tampSync1 <= TAMPER_IN;
         r_tampSync2 <= r_tampSync1;
      end
   end

   assign w_tamper = r_tampSync2;
`else
   logic w_unusedTamper;
   assign w_unusedTamper = TAMPER_IN;
   assign w_tamper       = 1'b0;
`endif

   // The mask applies after synchronization, so an enable change acts on
   // the very next edge without disturbing the synchronizer.
   assign w_trip    = r_sensSync2 & ZONE_EN_IN;
   assign w_anyTrip = |w_trip;
   // In SILENCED, only a zone that is not already latched re-triggers.
   assign w_newTrip = |(w_trip & ~r_alarmZones);

   // Next-state and alarm-zone logic. Per-state rules come first. Tamper can
   // then override the target. DISARM_IN has the final word over everything.
   always_comb begin
      w_nextState = r_state;
      w_zonesNext = r_alarmZones;
      w_armFail   = 1'b0;
      case (r_state)
         S_DISARMED: begin
            if (ARM_IN && !DISARM_IN) begin
               if (w_anyTrip) w_armFail   = 1'b1;
               else           w_nextState = S_EXIT;
            end
         end
         S_EXIT: begin
            if (r_cnt == '0) w_nextState = S_ARMED;
         end
         S_ARMED: begin
            if (w_anyTrip) begin
               w_nextState = S_ENTRY;
               w_zonesNext = r_alarmZones | w_trip;
            end
         end
         S_ENTRY: begin
            w_zonesNext = r_alarmZones | w_trip;
            if (r_cnt == '0) w_nextState = S_ALARM;
         end
         S_ALARM: begin
            w_zonesNext = r_alarmZones | w_trip;
            if ((r_cnt == '0) && (SIREN_TICKS != 0)) w_nextState = S_SILENCED;
         end
         S_SILENCED: begin
            if (w_newTrip) begin
               w_nextState = S_ALARM;
               w_zonesNext = r_alarmZones | w_trip;
            end
         end
         default: begin
            w_nextState = S_DISARMED;
            w_zonesNext = '0;
         end
      endcase
      if (w_tamper && !DISARM_IN) begin
         w_nextState = S_ALARM;
         w_armFail   = 1'b0;
      end
      if (DISARM_IN && (r_state != S_DISARMED)) begin
         w_nextState = S_DISARMED;
         w_zonesNext = '0;
         w_armFail   = 1'b0;
      end
   end

   assign w_stateChange = (w_nextState != r_state);

   // The counter reloads on every state entry, including SILENCED -> ALARM.
   // Otherwise it counts ticks down to zero and holds there.
   always_comb begin
      w_cntNext = r_cnt;
      if (w_stateChange)                 w_cntNext = loadFor(w_nextState);
      else if (TICK_IN && (r_cnt != '0)) w_cntNext = r_cnt - 1'b1;
   end

   // State and registered outputs. The siren follows the next state, so it
   // rises and falls on the same edge that enters or leaves ALARM.
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         r_state      <= S_DISARMED;
         r_cnt        <= '0;
         r_alarmZones <= '0;
         r_siren      <= 1'b0;
         r_armFail    <= 1'b0;
         r_statusSend <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_cnt        <= w_cntNext;
         r_alarmZones <= w_zonesNext;
         r_siren      <= (w_nextState == S_ALARM);
         r_armFail    <= w_armFail;
         r_statusSend <= w_stateChange;
      end
   end

   assign SIREN_OUT       = r_siren;
   assign STATE_OUT       = r_state;
   assign ALARM_ZONES_OUT = r_alarmZones;
   assign ARM_FAIL_OUT    = r_armFail;
   assign STATUS_SEND_OUT = r_statusSend;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_zone_controller
//
// Purpose:
//    Directed self-checking bench for alarm_zone_controller, configured with
//    4 zones, exit 3, entry 2 and siren 4 ticks. Ticks arrive every 4th cycle.
//    Tamper expectations follow ALARM_TAMPER_EN.
// -----------------------------------------------------------------------------
module tb_alarm_zone_controller;

   logic       clock;
   logic       reset;
   logic       tickIn;
   logic [3:0] sensorIn;
   logic [3:0] zoneEnIn;
   logic       armIn;
   logic       disarmIn;
   logic       tamperIn;
   logic       sirenOut;
   logic [2:0] stateOut;
   logic [3:0] alarmZonesOut;
   logic       armFailOut;
   logic       statusSendOut;

   int checks = 0;
   int errors = 0;

   alarm_zone_controller #(
      .N_ZONES    (4),
      .CNT_W      (8),
      .EXIT_TICKS (3),
      .ENTRY_TICKS(2),
      .SIREN_TICKS(4)
   ) dut (
      .CLK_IN         (clock),
      .RESET_IN       (reset),
      .TICK_IN        (tickIn),
      .SENSOR_IN      (sensorIn),
      .ZONE_EN_IN     (zoneEnIn),
      .ARM_IN         (armIn),
      .DISARM_IN      (disarmIn),
      .TAMPER_IN      (tamperIn),
      .SIREN_OUT      (sirenOut),
      .STATE_OUT      (stateOut),
      .ALARM_ZONES_OUT(alarmZonesOut),
      .ARM_FAIL_OUT   (armFailOut),
      .STATUS_SEND_OUT(statusSendOut)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n clock edges. Outputs are sampled 1 unit after each edge.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Deliver n ticks, each as three idle cycles followed by one tick cycle.
   task automatic tickCycles(input int n);
      repeat (n) begin
         tickIn = 1'b0;
         applyStimulus(3);
         tickIn = 1'b1;
         applyStimulus(1);
         tickIn = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence. Expected values are derived by hand: one edge
   // per applyStimulus cycle, and two edges of synchronizer delay before
   // the FSM sees a pin.
   initial begin
      reset = 1'b1; tickIn = 1'b0; sensorIn = 4'b0000; zoneEnIn = 4'b1111;
      armIn = 1'b0; disarmIn = 1'b0; tamperIn = 1'b0;
      applyStimulus(3);
      reset = 1'b0;
      checkOutput("rst_state", 16'(stateOut), 16'd0);
      checkOutput("rst_siren", 16'(sirenOut), 16'd0);
      checkOutput("rst_zones", 16'(alarmZonesOut), 16'd0);
      checkOutput("rst_armfail", 16'(armFailOut), 16'd0);
      checkOutput("rst_status", 16'(statusSendOut), 16'd0);

      // Arm cleanly into EXIT.
      applyStimulus(1);
      armIn = 1'b1;
      applyStimulus(1);
      armIn = 1'b0;
      checkOutput("arm_exit_state", 16'(stateOut), 16'd1);
      checkOutput("arm_status_pulse", 16'(statusSendOut), 16'd1);
      applyStimulus(1);
      checkOutput("arm_status_drop", 16'(statusSendOut), 16'd0);

      // The exit delay runs out after 3 ticks. ARMED follows on the next edge.
      tickCycles(2);
      checkOutput("exit_mid", 16'(stateOut), 16'd1);
      tickCycles(1);
      checkOutput("exit_cnt0", 16'(stateOut), 16'd1);
      applyStimulus(1);
      checkOutput("armed_state", 16'(stateOut), 16'd2);
      checkOutput("armed_status", 16'(statusSendOut), 16'd1);

      // Zone 1 trips. ENTRY is reached on the third edge.
      sensorIn = 4'b0010;
      applyStimulus(2);
      checkOutput("sync_latency", 16'(stateOut), 16'd2);
      applyStimulus(1);
      checkOutput("entry_state", 16'(stateOut), 16'd3);
      checkOutput("entry_zones", 16'(alarmZonesOut), 16'd2);
      checkOutput("entry_siren", 16'(sirenOut), 16'd0);

      // The entry delay is 2 ticks, then ALARM.
      tickCycles(2);
      checkOutput("entry_cnt0", 16'(stateOut), 16'd3);
      applyStimulus(1);
      checkOutput("alarm_state", 16'(stateOut), 16'd4);
      checkOutput("alarm_siren", 16'(sirenOut), 16'd1);
      checkOutput("alarm_zones", 16'(alarmZonesOut), 16'h2);

      // The siren times out after 4 ticks. The latched zone 1 does not re-alarm.
      tickCycles(4);
      checkOutput("siren_cnt0", 16'(stateOut), 16'd4);
      applyStimulus(1);
      checkOutput("silenced_state", 16'(stateOut), 16'd5);
      checkOutput("silenced_siren", 16'(sirenOut), 16'd0);
      applyStimulus(3);
      checkOutput("silenced_hold", 16'(stateOut), 16'd5);

      // A new zone 3 trip re-alarms.
      sensorIn = 4'b1010;
      applyStimulus(2);
      checkOutput("realarm_wait", 16'(stateOut), 16'd5);
      applyStimulus(1);
      checkOutput("realarm_state", 16'(stateOut), 16'd4);
      checkOutput("realarm_siren", 16'(sirenOut), 16'd1);
      checkOutput("realarm_zones", 16'(alarmZonesOut), 16'hA);

      // Reset held during ALARM clears everything on the first edge.
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("midrst_state", 16'(stateOut), 16'd0);
      checkOutput("midrst_siren", 16'(sirenOut), 16'd0);
      checkOutput("midrst_zones", 16'(alarmZonesOut), 16'd0);
      sensorIn = 4'b0100;
      applyStimulus(2);
      reset = 1'b0;

      // The arm request is refused while zone 2 is tripped.
      applyStimulus(2);
      armIn = 1'b1;
      applyStimulus(1);
      armIn = 1'b0;
      checkOutput("armfail_pulse", 16'(armFailOut), 16'd1);
      checkOutput("armfail_state", 16'(stateOut), 16'd0);
      applyStimulus(1);
      checkOutput("armfail_drop", 16'(armFailOut), 16'd0);

      // With zone 2 masked off, arming succeeds.
      zoneEnIn = 4'b1011;
      armIn = 1'b1;
      applyStimulus(1);
      armIn = 1'b0;
      checkOutput("masked_arm_state", 16'(stateOut), 16'd1);
      checkOutput("masked_arm_fail", 16'(armFailOut), 16'd0);
      tickCycles(3);
      applyStimulus(1);
      checkOutput("masked_armed", 16'(stateOut), 16'd2);

      // Re-enabling zone 2 trips it on the very next edge.
      zoneEnIn = 4'b1111;
      applyStimulus(1);
      checkOutput("unmask_entry", 16'(stateOut), 16'd3);
      checkOutput("unmask_zones", 16'(alarmZonesOut), 16'h4);

      // DISARM_IN and ARM_IN arrive together in ENTRY. Disarm wins.
      disarmIn = 1'b1; armIn = 1'b1;
      applyStimulus(1);
      disarmIn = 1'b0; armIn = 1'b0;
      checkOutput("disarm_state", 16'(stateOut), 16'd0);
      checkOutput("disarm_siren", 16'(sirenOut), 16'd0);
      checkOutput("disarm_zones", 16'(alarmZonesOut), 16'd0);
      checkOutput("disarm_armfail", 16'(armFailOut), 16'd0);
      checkOutput("disarm_status", 16'(statusSendOut), 16'd1);

      // Open the tamper loop while DISARMED.
      sensorIn = 4'b0000;
      applyStimulus(2);
      tamperIn = 1'b1;
      applyStimulus(3);
`ifdef ALARM_TAMPER_EN
      checkOutput("tamper_state", 16'(stateOut), 16'd4);
      checkOutput("tamper_siren", 16'(sirenOut), 16'd1);
      disarmIn = 1'b1;
      applyStimulus(1);
      disarmIn = 1'b0;
      checkOutput("tamper_disarm", 16'(stateOut), 16'd0);
      applyStimulus(1);
      checkOutput("tamper_realarm", 16'(stateOut), 16'd4);
`else
      checkOutput("tamper_state", 16'(stateOut), 16'd0);
      checkOutput("tamper_siren", 16'(sirenOut), 16'd0);
`endif
      tamperIn = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
